// File: rtl/clk_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_gen
// Brief    : Master-clock phase generator: binary divider chain with level and
//            rise/fall strobe outputs, wakestate offsets, resync and hold.
// Revision : 1.0 - initial release
// ============================================================================
module clk_phase_gen #(
    parameter int CNT_W    = 4,
    parameter int SYNC_VAL = 0,
    parameter int WS0_OFFS = 0,
    parameter int WS1_OFFS = 1,
    parameter int WS2_OFFS = 2,
    parameter int WS3_OFFS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ws_i,
    input  logic             sync_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] clk_o,
    output logic [CNT_W-1:0] rise_o,
    output logic [CNT_W-1:0] fall_o
);

    function automatic logic [CNT_W-1:0] ws_offs(input logic [1:0] ws);
        logic [CNT_W-1:0] r;
        case (ws)
            2'd0:    r = CNT_W'(WS0_OFFS);
            2'd1:    r = CNT_W'(WS1_OFFS);
            2'd2:    r = CNT_W'(WS2_OFFS);
            default: r = CNT_W'(WS3_OFFS);
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] offs_q, offs_d;
    logic             sync_dly_q;
    logic [1:0]       ws_cur_q, ws_cur_d;
    logic [1:0]       ws_pend_q, ws_pend_d;
    logic             pend_v_q, pend_v_d;
    logic [CNT_W-1:0] clk_q, rise_q, fall_q;
    logic [CNT_W-1:0] ph_d, rise_d, fall_d;

    logic       sync_edge;
    logic       advance;
    logic       apply;
    logic       ws_chg;
    logic [1:0] ws_tgt;

    always_comb begin
        sync_edge = sync_i & ~sync_dly_q;
        advance   = sync_edge | ~hold_i;

        if (sync_edge)
            cnt_d = CNT_W'(SYNC_VAL);
        else if (hold_i)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        // A new wakestate only takes effect at the counter wrap so the phase
        // relationship of the slower clocks is never torn mid-period.
        ws_tgt    = pend_v_q ? ws_pend_q : ws_cur_q;
        ws_chg    = (ws_i != ws_tgt);
        apply     = pend_v_q & (&cnt_q) & advance;
        offs_d    = apply ? ws_offs(ws_pend_q) : offs_q;
        ws_cur_d  = apply ? ws_pend_q : ws_cur_q;
        ws_pend_d = ws_chg ? ws_i : ws_pend_q;
        pend_v_d  = ws_chg | (pend_v_q & ~apply);

        ph_d   = cnt_d + offs_d;
        rise_d = ph_d & ~clk_q;
        fall_d = ~ph_d & clk_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            offs_q     <= ws_offs(ws_i);
            sync_dly_q <= 1'b0;
            ws_cur_q   <= ws_i;
            ws_pend_q  <= ws_i;
            pend_v_q   <= 1'b0;
            clk_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            offs_q     <= offs_d;
            sync_dly_q <= sync_i;
            ws_cur_q   <= ws_cur_d;
            ws_pend_q  <= ws_pend_d;
            pend_v_q   <= pend_v_d;
            clk_q      <= ph_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign clk_o  = clk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_phase_gen
// Brief    : Directed self-checking bench for clk_phase_gen (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_phase_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ws_i  = 2'd0;
    logic       sync_i = 1'b0;
    logic       hold_i = 1'b0;
    logic [3:0] clk_o, rise_o, fall_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] prev_exp = 4'd0;
    int rise3_cnt;
    int rise0_cnt;

    clk_phase_gen dut (
        .clock  (clock),
        .reset  (reset),
        .ws_i   (ws_i),
        .sync_i (sync_i),
        .hold_i (hold_i),
        .clk_o  (clk_o),
        .rise_o (rise_o),
        .fall_o (fall_o)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected strobes follow directly from the expected level sequence.
    task automatic expect_cycle(input string tag, input int e);
        logic [3:0] ev;
        ev = 4'(e);
        tick();
        check_val({tag, ".clk"},  32'(clk_o),  32'(ev));
        check_val({tag, ".rise"}, 32'(rise_o), 32'(ev & ~prev_exp));
        check_val({tag, ".fall"}, 32'(fall_o), 32'(~ev & prev_exp));
        prev_exp = ev;
    endtask

    initial begin
        // 1: reset then free run with wakestate 0
        tick();
        tick();
        check_val("rst.clk",  32'(clk_o),  32'd0);
        check_val("rst.rise", 32'(rise_o), 32'd0);
        check_val("rst.fall", 32'(fall_o), 32'd0);
        reset = 1'b0;
        rise3_cnt = 0;
        rise0_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            expect_cycle("run", i % 16);
            if (rise_o[3]) rise3_cnt++;
            if (rise_o[0]) rise0_cnt++;
            if (i == 1) check_val("first.rise", 32'(rise_o), 32'd1);
        end
        check_val("rise3_once", 32'(rise3_cnt), 32'd1);
        check_val("rise0_count", 32'(rise0_cnt), 32'd8);

        // 2: wakestate 0 -> 2 requested at cnt=5, applied after cnt=15
        for (int i = 1; i <= 5; i++) expect_cycle("pre_ws", i);
        ws_i = 2'd2;
        for (int i = 6; i <= 15; i++) expect_cycle("ws_wait", i);
        expect_cycle("ws_apply", 2);
        check_val("ws_apply.fall", 32'(fall_o), 32'hD);
        check_val("ws_apply.rise", 32'(rise_o), 32'h0);
        expect_cycle("ws_run", 3);
        expect_cycle("ws_run", 4);

        // back to wakestate 0 so the resync lands on clk_o=0
        ws_i = 2'd0;
        for (int c = 3; c <= 15; c++) expect_cycle("ws0_wait", (c + 2) % 16);
        expect_cycle("ws0_apply", 0);
        for (int i = 1; i <= 9; i++) expect_cycle("pre_sync", i);

        // 3: sync pulse at cnt=9
        sync_i = 1'b1;
        expect_cycle("sync", 0);
        check_val("sync.fall", 32'(fall_o), 32'h9);
        sync_i = 1'b0;
        expect_cycle("post_sync", 1);

        // 4: hold at clk_o=3 for 5 cycles
        expect_cycle("pre_hold", 2);
        expect_cycle("pre_hold", 3);
        hold_i = 1'b1;
        for (int i = 0; i < 5; i++) expect_cycle("hold", 3);
        hold_i = 1'b0;
        expect_cycle("unhold", 4);
        check_val("unhold.rise", 32'(rise_o), 32'h4);
        check_val("unhold.fall", 32'(fall_o), 32'h3);

        // 5: sync edge overrides hold; level held high resyncs once
        hold_i = 1'b1;
        expect_cycle("hold2", 4);
        sync_i = 1'b1;
        expect_cycle("sync_hold", 0);
        expect_cycle("sync_hold2", 0);
        hold_i = 1'b0;
        for (int i = 1; i <= 8; i++) expect_cycle("sync_high", i);
        sync_i = 1'b0;
        expect_cycle("sync_low", 9);

        // 6: reset at clk_o=7, release with wakestate 3
        for (int i = 10; i <= 23; i++) expect_cycle("to7", i % 16);
        reset = 1'b1;
        ws_i  = 2'd3;
        tick();
        check_val("midrst.clk",  32'(clk_o),  32'd0);
        check_val("midrst.rise", 32'(rise_o), 32'd0);
        check_val("midrst.fall", 32'(fall_o), 32'd0);
        prev_exp = 4'd0;
        reset = 1'b0;
        expect_cycle("rel_ws3", 4);
        check_val("rel_ws3.rise", 32'(rise_o), 32'h4);
        expect_cycle("rel_ws3_run", 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
